// File: rtl/reg_seq_pkg.sv
// reg_seq_pkg: shared definitions for the register-transfer sequencer.
// Holds the FSM state encoding and the one-hot strobe decoder.
// No logic; imported by reg_transfer_sequencer.
package reg_seq_pkg;

  // Widest strobe vector the decoder can produce.
  // Instances must keep REG_COUNT at or below this.
  localparam int ONEHOT_W = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_LATCH,
    S_WRITE,
    S_DONE
  } seq_state_e;

  // An index at or beyond ONEHOT_W shifts the bit out and returns zero.
  // Callers truncate to REG_COUNT, so any index >= REG_COUNT decodes to an
  // all-zero strobe.
  function automatic logic [ONEHOT_W-1:0] onehot(input int unsigned idx);
    return ONEHOT_W'(1) << idx;
  endfunction

endpackage

// File: rtl/reg_transfer_sequencer_cmd_fifo.sv
// cmd_fifo: generic synchronous show-ahead FIFO.
// Latency: an entry pushed at edge N is visible on pop_dat after edge N.
// Backpressure: push is ignored while full; pop is ignored while empty.
// Ports: clk/reset (async active-low), push/push_dat, full, pop/pop_dat, empty.
module cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4   // power of two, >= 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // The extra MSB on each pointer tells full apart from empty when the
  // address bits are equal.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset; the pointers decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/reg_transfer_sequencer.sv
// reg_transfer_sequencer: serialises register moves and immediate loads into a register file.
// Latency: the write strobe follows the pop by 3 cycles for a move and 1 cycle for an immediate.
//          Throughput is one move per 5 cycles or one immediate per 3 cycles.
// Backpressure: cmd_ready is low while the command FIFO is full and until the first edge after reset.
// Ports: cmd_* valid/ready command input; read_en/write_en/datain/dataout drive the register file;
//        busy, done (one-cycle pulse after each write) and err (sticky) report status.
// Build option: defining SEQ_IDX_CHECK_EN discards out-of-range commands at pop and sets err.
module reg_transfer_sequencer
  import reg_seq_pkg::*;
#(
  parameter int REG_COUNT  = 11,
  parameter int REG_WIDTH  = 12,
  parameter int IDX_W      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_imm,
  input  logic [IDX_W-1:0]     cmd_src,
  input  logic [IDX_W-1:0]     cmd_dst,
  input  logic [REG_WIDTH-1:0] cmd_data,
  output logic [REG_COUNT-1:0] read_en,
  output logic [REG_COUNT-1:0] write_en,
  output logic [REG_WIDTH-1:0] datain,
  input  logic [REG_WIDTH-1:0] dataout,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  typedef struct packed {
    logic                 imm;
    logic [IDX_W-1:0]     src;
    logic [IDX_W-1:0]     dst;
    logic [REG_WIDTH-1:0] data;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

  cmd_t             push_cmd;
  cmd_t             head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic             ready_q;
  logic             head_bad;
  seq_state_e       state;
  logic [IDX_W-1:0] cur_src;
  logic [IDX_W-1:0] cur_dst;
  logic [REG_COUNT-1:0] src_oh;
  logic [REG_COUNT-1:0] dst_oh;

  assign push_cmd  = {cmd_imm, cmd_src, cmd_dst, cmd_data};
  // ready_q holds the port low until the first edge after reset, so nothing
  // is offered as accepted while the FIFO is still held in reset.
  assign cmd_ready = ready_q && !fifo_full;
  assign fifo_pop  = (state == S_IDLE) && !fifo_empty;
  assign busy      = (state != S_IDLE) || !fifo_empty;

  cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (cmd_valid && cmd_ready),
    .push_dat (push_cmd),
    .full     (fifo_full),
    .pop      (fifo_pop),
    .pop_dat  (head),
    .empty    (fifo_empty)
  );

  // Out-of-range indices decode to a zero strobe.
  assign src_oh = REG_COUNT'(onehot(32'(cur_src)));
  assign dst_oh = REG_COUNT'(onehot(32'(cur_dst)));

`ifdef SEQ_IDX_CHECK_EN
  logic err_q;

  // src is only checked for moves; an immediate never reads it.
  assign head_bad = (int'(head.dst) >= REG_COUNT) ||
                    (!head.imm && (int'(head.src) >= REG_COUNT));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                    err_q <= 1'b0;
    else if (fifo_pop && head_bad) err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign head_bad = 1'b0;
  assign err      = 1'b0;
`endif

  // Each state's strobe is set on the edge that leaves that state, so the
  // strobe is high for exactly the cycle that follows.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      cur_src  <= '0;
      cur_dst  <= '0;
      read_en  <= '0;
      write_en <= '0;
      datain   <= '0;
      done     <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      done    <= 1'b0;
      case (state)
        S_IDLE: begin
          // A rejected command is dropped here and the FSM stays in IDLE,
          // so the next head can pop on the following cycle.
          if (fifo_pop && !head_bad) begin
            cur_src <= head.src;
            cur_dst <= head.dst;
            if (head.imm) begin
              datain <= head.data;
              state  <= S_WRITE;
            end else begin
              state  <= S_READ;
            end
          end
        end
        S_READ: begin
          read_en <= src_oh;
          state   <= S_LATCH;
        end
        S_LATCH: begin
          // dataout is sampled at the end of the read-strobe cycle.
          read_en <= '0;
          datain  <= dataout;
          state   <= S_WRITE;
        end
        S_WRITE: begin
          write_en <= dst_oh;
          state    <= S_DONE;
        end
        S_DONE: begin
          write_en <= '0;
          done     <= 1'b1;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_transfer_sequencer.sv
// Bench for reg_transfer_sequencer. It models the register file, checks cycle
// timing with a vector table, and compares the write log of random commands
// with a command-level reference model.
module tb_reg_transfer_sequencer;

  localparam int NREG = 11;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_imm;
  logic [3:0]  cmd_src;
  logic [3:0]  cmd_dst;
  logic [11:0] cmd_data;
  logic [10:0] read_en;
  logic [10:0] write_en;
  logic [11:0] datain;
  logic [11:0] dataout;
  logic        busy;
  logic        done;
  logic        err;

  reg_transfer_sequencer #(
    .REG_COUNT  (11),
    .REG_WIDTH  (12),
    .IDX_W      (4),
    .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_imm   (cmd_imm),
    .cmd_src   (cmd_src),
    .cmd_dst   (cmd_dst),
    .cmd_data  (cmd_data),
    .read_en   (read_en),
    .write_en  (write_en),
    .datain    (datain),
    .dataout   (dataout),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file seen by the DUT: combinational read, write on the clock edge.
  logic [11:0] rf [NREG];
  always_comb begin
    dataout = '0;
    for (int i = 0; i < NREG; i++) if (read_en[i]) dataout = dataout | rf[i];
  end
  always @(posedge clk) begin
    for (int i = 0; i < NREG; i++) if (write_en[i]) rf[i] <= datain;
  end

  // The monitor only records what it sees; all comparisons are made in the main test.
  typedef struct { int dst; logic [11:0] val; } wr_t;
  wr_t obs_q [$];
  int  obs_done = 0;
  int  viol     = 0;

  function automatic int lowest(input logic [10:0] v);
    for (int i = 0; i < 11; i++) if (v[i]) return i;
    return -1;
  endfunction

  always @(posedge clk) begin
    if (write_en != '0) obs_q.push_back('{dst: lowest(write_en), val: datain});
    if (done) obs_done <= obs_done + 1;
    if ($countones(write_en) > 1 || $countones(read_en) > 1 ||
        (write_en != '0 && read_en != '0)) viol <= viol + 1;
  end

  // Reference model: architectural register contents, the expected write log
  // and the expected number of done pulses.
  logic [11:0] m_rf [NREG];
  wr_t         exp_q [$];
  int          exp_done = 0;
  logic        exp_err  = 1'b0;
  int          obs_idx  = 0;
  int          checks   = 0;
  int          failures = 0;

  task automatic model(input logic imm, input int src, input int dst, input logic [11:0] data);
    logic [11:0] v;
`ifdef SEQ_IDX_CHECK_EN
    if (dst >= NREG || (!imm && src >= NREG)) begin
      exp_err = 1'b1;
      return;
    end
`endif
    v = imm ? data : ((src < NREG) ? m_rf[src] : 12'h000);
    if (dst < NREG) begin
      m_rf[dst] = v;
      exp_q.push_back('{dst: dst, val: v});
    end
    exp_done++;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Present one command and return right after the edge that accepts it.
  // cmd_valid stays high; the caller follows with another drive or idle_bus.
  task automatic drive(input logic imm, input logic [3:0] src, input logic [3:0] dst,
                       input logic [11:0] data);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_imm = imm; cmd_src = src; cmd_dst = dst; cmd_data = data;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      chk("send_timeout", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
    end else begin
      @(posedge clk);
    end
  endtask

  task automatic send(input logic imm, input logic [3:0] src, input logic [3:0] dst,
                      input logic [11:0] data);
    model(imm, int'(src), int'(dst), data);
    drive(imm, src, dst, data);
  endtask

  task automatic idle_bus();
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  // Compare every write observed since the last call with the model's log.
  task automatic check_log(input string nm);
    repeat (3) @(negedge clk);
    chk({nm, "_wr_count"}, 32'(obs_q.size() - obs_idx), 32'(exp_q.size()));
    while (exp_q.size() > 0 && obs_idx < obs_q.size()) begin
      chk({nm, "_wr_dst"}, 32'(obs_q[obs_idx].dst), 32'(exp_q[0].dst));
      chk({nm, "_wr_val"}, 32'(obs_q[obs_idx].val), 32'(exp_q[0].val));
      void'(exp_q.pop_front());
      obs_idx++;
    end
    exp_q.delete();
    obs_idx = obs_q.size();
  endtask

  typedef struct {
    logic        imm;
    logic [3:0]  src;
    logic [3:0]  dst;
    logic [11:0] data;      // immediate, or the value preloaded into src for a move
    logic [10:0] exp_rd;
    logic [10:0] exp_wr;
    logic [11:0] exp_val;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int wc;

    vecs[0] = '{1'b1, 4'd0,  4'd0,  12'h704, 11'h000, 11'h001, 12'h704};
    vecs[1] = '{1'b0, 4'd0,  4'd3,  12'h684, 11'h001, 11'h008, 12'h684};
    vecs[2] = '{1'b0, 4'd5,  4'd5,  12'hABC, 11'h020, 11'h020, 12'hABC};
    vecs[3] = '{1'b1, 4'd0,  4'd10, 12'hFFF, 11'h000, 11'h400, 12'hFFF};
    vecs[4] = '{1'b0, 4'd10, 4'd1,  12'h001, 11'h400, 11'h002, 12'h001};
    vecs[5] = '{1'b1, 4'd9,  4'd7,  12'h000, 11'h000, 11'h080, 12'h000};

    // Reset with a command offered: nothing may be accepted or driven.
    reset = 1'b0; cmd_valid = 1'b1; cmd_imm = 1'b1; cmd_src = 4'd0; cmd_dst = 4'd2;
    cmd_data = 12'h5A5;
    repeat (2) @(negedge clk);
    chk("rst_read_en",  32'(read_en),  32'd0);
    chk("rst_write_en", 32'(write_en), 32'd0);
    chk("rst_datain",   32'(datain),   32'd0);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_done",     32'(done),     32'd0);
    chk("rst_err",      32'(err),      32'd0);
    reset = 1'b1; cmd_valid = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_no_push_busy", 32'(busy), 32'd0);

    // Give every register a defined value.
    for (int i = 0; i < NREG; i++) send(1'b1, 4'd0, 4'(i), 12'($urandom));
    idle_bus();
    wait_idle();
    check_log("preload");

    // Cycle-exact timing from the table. k counts negedges after the pop edge.
    for (int v = 0; v < 6; v++) begin
      if (!vecs[v].imm) begin
        send(1'b1, 4'd0, vecs[v].src, vecs[v].data);
        idle_bus();
        wait_idle();
      end
      send(vecs[v].imm, vecs[v].src, vecs[v].dst, vecs[v].data);
      idle_bus();
      @(posedge clk);
      wc = vecs[v].imm ? 1 : 3;
      for (int k = 0; k <= wc + 2; k++) begin
        @(negedge clk);
        chk($sformatf("v%0d_k%0d_read_en", v, k), 32'(read_en),
            (!vecs[v].imm && k == 1) ? 32'(vecs[v].exp_rd) : 32'd0);
        chk($sformatf("v%0d_k%0d_write_en", v, k), 32'(write_en),
            (k == wc) ? 32'(vecs[v].exp_wr) : 32'd0);
        chk($sformatf("v%0d_k%0d_done", v, k), 32'(done), (k == wc + 1) ? 32'd1 : 32'd0);
        if (k == wc) chk($sformatf("v%0d_datain", v), 32'(datain), 32'(vecs[v].exp_val));
      end
      chk($sformatf("v%0d_busy_end", v), 32'(busy), 32'd0);
    end
    check_log("table");

    // Backpressure: a move keeps the FSM busy while four immediates fill the FIFO.
    send(1'b0, 4'd6, 4'd0, 12'h000);
    for (int i = 1; i <= 4; i++) send(1'b1, 4'd0, 4'(i), 12'h100 + 12'(i));
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("bp_ready_low", 32'(cmd_ready), 32'd0);
    chk("bp_busy", 32'(busy), 32'd1);
    send(1'b1, 4'd0, 4'd5, 12'h105);
    idle_bus();
    wait_idle();
    check_log("backpressure");

    // Random commands checked against the model.
    for (int n = 0; n < 60; n++) begin
      send(1'($urandom_range(0, 1)), 4'($urandom_range(0, 10)), 4'($urandom_range(0, 10)),
           12'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        idle_bus();
        repeat ($urandom_range(0, 6)) @(negedge clk);
      end
    end
    idle_bus();
    wait_idle();
    check_log("random");

    // Reset during LATCH aborts the move and flushes the queued command.
    // These commands never complete, so they bypass the model.
    drive(1'b0, 4'd2, 4'd7, 12'h000);
    drive(1'b1, 4'd0, 4'd4, 12'h123);
    idle_bus();
    @(negedge clk);
    chk("mid_read_en_pre", 32'(read_en), 32'h004);
    reset = 1'b0;
    #1;
    chk("mid_read_en",  32'(read_en),  32'd0);
    chk("mid_write_en", 32'(write_en), 32'd0);
    chk("mid_done",     32'(done),     32'd0);
    chk("mid_busy",     32'(busy),     32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_ready", 32'(cmd_ready), 32'd1);
    repeat (6) @(negedge clk);
    chk("mid_busy_after", 32'(busy), 32'd0);
    check_log("midreset");

    // Out-of-range indices.
    send(1'b1, 4'd0, 4'd12, 12'h555);
    send(1'b0, 4'd13, 4'd6, 12'h000);
    send(1'b1, 4'd0, 4'd8, 12'h3C3);
    idle_bus();
    wait_idle();
    check_log("oor");
`ifdef SEQ_IDX_CHECK_EN
    chk("oor_err_set", 32'(err), 32'd1);
`else
    chk("oor_err_zero", 32'(err), 32'd0);
`endif

    chk("onehot_viol", 32'(viol), 32'd0);
    chk("done_count", 32'(obs_done), 32'(exp_done));
    chk("err_final", 32'(err), 32'(exp_err));
    for (int i = 0; i < NREG; i++) chk($sformatf("rf%0d", i), 32'(rf[i]), 32'(m_rf[i]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
